// File: rtl/fg_button_debouncer_if.sv
// Signal bundle between one front-panel button's synchronizer and its debouncer.
// The master side drives the synchronized level. The slave side returns the cleaned events.
interface fg_button_debouncer_if;
    logic sync_i;
    logic level_o;
    logic press_o;
    logic release_o;
    logic long_o;
    logic repeat_o;

    modport master (
        output sync_i,
        input  level_o,
        input  press_o,
        input  release_o,
        input  long_o,
        input  repeat_o
    );

    modport slave (
        input  sync_i,
        output level_o,
        output press_o,
        output release_o,
        output long_o,
        output repeat_o
    );
endinterface

// File: rtl/fg_button_debouncer.sv
// Debouncer for one synchronized button. It produces the debounced level, press and release pulses,
// a long-press pulse and auto-repeat pulses while the button is held. All outputs are registered.
//
// state     | meaning
// ----------+------------------------------------------------------------
// STABLE_LO | released level accepted; waiting for a pressed sample
// PEND_HI   | counting consecutive pressed samples toward a press
// STABLE_HI | pressed level accepted; hold/repeat timing running
// PEND_LO   | counting consecutive released samples; hold timing continues
module fg_button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LONG_CYCLES     = 1024,
    parameter int REPEAT_CYCLES   = 256,
    parameter bit REPEAT_EN       = 1'b1,
    parameter bit INVERT          = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fg_button_debouncer_if.slave  bif
);

    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_CYCLES);
    localparam bit                BYPASS   = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [HOLD_W-1:0]  hold_q, hold_d, hold_inc;
    logic [REP_W-1:0]   rep_q, rep_d, rep_inc;
    logic               level_q, level_d;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               long_q, long_d;
    logic               repeat_q, repeat_d;
    logic               p;
    logic               accept_press;
    logic               accept_rel;

    assign p        = bif.sync_i ^ INVERT;
    assign hold_inc = hold_q + HOLD_W'(1);
    assign rep_inc  = rep_q + REP_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= STABLE_LO;
            deb_q     <= '0;
            hold_q    <= '0;
            rep_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_q     <= deb_d;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        deb_d        = deb_q;
        hold_d       = hold_q;
        rep_d        = rep_q;
        level_d      = level_q;
        press_d      = 1'b0;
        release_d    = 1'b0;
        long_d       = 1'b0;
        repeat_d     = 1'b0;
        accept_press = 1'b0;
        accept_rel   = 1'b0;

        case (state_q)
            STABLE_LO: begin
                if (p) begin
                    if (BYPASS) begin
                        accept_press = 1'b1;
                    end else begin
                        state_d = PEND_HI;
                        deb_d   = DEB_W'(1);
                    end
                end
            end
            PEND_HI: begin
                if (!p) begin
                    state_d = STABLE_LO;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    accept_press = 1'b1;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            STABLE_HI: begin
                if (!p) begin
                    if (BYPASS) begin
                        accept_rel = 1'b1;
                    end else begin
                        state_d = PEND_LO;
                        deb_d   = DEB_W'(1);
                    end
                end
            end
            PEND_LO: begin
                // A bounce back to pressed only abandons the release; hold timing keeps running.
                if (p) begin
                    state_d = STABLE_HI;
                    deb_d   = '0;
                end else if (deb_q == DEB_LAST) begin
                    accept_rel = 1'b1;
                end else begin
                    deb_d = deb_q + DEB_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                deb_d   = '0;
            end
        endcase

        if (accept_press) begin
            state_d = STABLE_HI;
            deb_d   = '0;
            level_d = 1'b1;
            press_d = 1'b1;
            hold_d  = '0;
            rep_d   = '0;
        end

        // A release on this edge takes precedence over any long or repeat pulse due on the same edge.
        if (level_q) begin
            if (accept_rel) begin
                state_d   = STABLE_LO;
                deb_d     = '0;
                level_d   = 1'b0;
                release_d = 1'b1;
                hold_d    = '0;
                rep_d     = '0;
            end else if (hold_q != HOLD_MAX) begin
                hold_d = hold_inc;
                long_d = (hold_inc == HOLD_MAX);
            end else if (REPEAT_EN) begin
                if (rep_inc == REP_MAX) begin
                    repeat_d = 1'b1;
                    rep_d    = '0;
                end else begin
                    rep_d = rep_inc;
                end
            end
        end
    end

    assign bif.level_o   = level_q;
    assign bif.press_o   = press_q;
    assign bif.release_o = release_q;
    assign bif.long_o    = long_q;
    assign bif.repeat_o  = repeat_q;

endmodule

// File: tb/tb_fg_button_debouncer.sv
// Bench for fg_button_debouncer. Three instances with different parameter sets are driven with
// directed scenarios and then random bouncing, and each is compared against a run-length reference model.
module tb_fg_button_debouncer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fg_button_debouncer_if if0();
    fg_button_debouncer_if if1();
    fg_button_debouncer_if if2();

    logic sync_v [3];
    assign if0.sync_i = sync_v[0];
    assign if1.sync_i = sync_v[1];
    assign if2.sync_i = sync_v[2];

    fg_button_debouncer #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(5),
                          .REPEAT_EN(1'b1), .INVERT(1'b0))
        u0 (.clk_i(clk), .rst_i(rst), .bif(if0.slave));
    fg_button_debouncer #(.DEBOUNCE_CYCLES(2), .LONG_CYCLES(10), .REPEAT_CYCLES(3),
                          .REPEAT_EN(1'b1), .INVERT(1'b0))
        u1 (.clk_i(clk), .rst_i(rst), .bif(if1.slave));
    fg_button_debouncer #(.DEBOUNCE_CYCLES(3), .LONG_CYCLES(12), .REPEAT_CYCLES(4),
                          .REPEAT_EN(1'b0), .INVERT(1'b1))
        u2 (.clk_i(clk), .rst_i(rst), .bif(if2.slave));

    // Output vector per instance: {level, press, release, long, repeat}
    logic [4:0] obs [3];
    assign obs[0] = {if0.level_o, if0.press_o, if0.release_o, if0.long_o, if0.repeat_o};
    assign obs[1] = {if1.level_o, if1.press_o, if1.release_o, if1.long_o, if1.repeat_o};
    assign obs[2] = {if2.level_o, if2.press_o, if2.release_o, if2.long_o, if2.repeat_o};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         m_level [3];
    int         m_run   [3];
    int         m_last  [3];
    int         m_held  [3];
    logic [4:0] exp_v   [3];

    function automatic int p_d(int i);
        case (i) 0: return 4; 1: return 2; default: return 3; endcase
    endfunction
    function automatic int p_l(int i);
        case (i) 0: return 20; 1: return 10; default: return 12; endcase
    endfunction
    function automatic int p_r(int i);
        case (i) 0: return 5; 1: return 3; default: return 4; endcase
    endfunction
    function automatic int p_en(int i);
        return (i == 2) ? 0 : 1;
    endfunction
    function automatic int p_inv(int i);
        return (i == 2) ? 1 : 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_level[i] = 0;
            m_run[i]   = 0;
            m_last[i]  = -1;
            m_held[i]  = 0;
            exp_v[i]   = 5'b0;
        end
    endtask

    // A level change is accepted once the last D samples all disagree with the current level.
    // Pulses come from the number of edges the accepted press has been held.
    task automatic model_step(int i);
        int p;
        logic pr, rl, lg, rp;
        p  = (sync_v[i] ? 1 : 0) ^ p_inv(i);
        pr = 1'b0; rl = 1'b0; lg = 1'b0; rp = 1'b0;
        m_run[i]  = (p == m_last[i]) ? m_run[i] + 1 : 1;
        m_last[i] = p;
        if (p != m_level[i] && m_run[i] >= p_d(i)) begin
            m_level[i] = p;
            m_held[i]  = 0;
            if (p == 1) pr = 1'b1;
            else        rl = 1'b1;
        end else if (m_level[i] == 1) begin
            m_held[i]++;
            if (m_held[i] == p_l(i))
                lg = 1'b1;
            else if (p_en(i) == 1 && m_held[i] > p_l(i) && (m_held[i] - p_l(i)) % p_r(i) == 0)
                rp = 1'b1;
        end
        exp_v[i] = {(m_level[i] == 1), pr, rl, lg, rp};
    endtask

    task automatic check_vec(string tag, logic [4:0] o, logic [4:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic check_bit(string tag, logic o, logic e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic check_int(string tag, int o, int e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, o, e);
        end
    endtask

    // One active edge: advance the model with the sampled inputs, then compare just after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model_clear();
        else for (int i = 0; i < 3; i++) model_step(i);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++)
            check_vec($sformatf("u%0d cyc%0d", i, cyc), obs[i], exp_v[i]);
    endtask

    task automatic ticks(int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int rem [3];
    int press_n, long_n, rep_n;

    initial begin
        rst = 1'b1;
        sync_v[0] = 1'b1; sync_v[1] = 1'b1; sync_v[2] = 1'b0;
        model_clear();
        #2;
        for (int i = 0; i < 3; i++) check_vec($sformatf("reset u%0d", i), obs[i], 5'b0);
        ticks(2);
        sync_v[0] = 1'b0; sync_v[1] = 1'b0; sync_v[2] = 1'b1;
        rst = 1'b0;
        ticks(3);

        // Clean press on u0 (D=4), held 10 edges, then released.
        sync_v[0] = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick();
            check_bit($sformatf("t1 level j%0d", j), obs[0][4], j >= 4);
            check_bit($sformatf("t1 press j%0d", j), obs[0][3], j == 4);
        end
        sync_v[0] = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            tick();
            check_bit($sformatf("t1 release j%0d", j), obs[0][2], j == 4);
        end

        // 3-edge high glitch must not press; 3-edge low glitch while held must not release.
        sync_v[0] = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            tick();
            check_bit($sformatf("t2 glitch press j%0d", j), obs[0][3], 1'b0);
        end
        sync_v[0] = 1'b0;
        ticks(4);
        sync_v[0] = 1'b1;
        ticks(6);
        sync_v[0] = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            tick();
            check_bit($sformatf("t2 held level j%0d", j), obs[0][4], 1'b1);
            check_bit($sformatf("t2 no release j%0d", j), obs[0][2], 1'b0);
        end
        sync_v[0] = 1'b1;
        ticks(4);
        sync_v[0] = 1'b0;
        ticks(6);

        // u1 (D=2, L=10, R=3): long press timing followed by repeats, then release.
        sync_v[1] = 1'b1;
        ticks(2);
        check_bit("t3 press", obs[1][3], 1'b1);
        for (int j = 1; j <= 20; j++) begin
            tick();
            check_bit($sformatf("t3 long j%0d", j), obs[1][1], j == 10);
            check_bit($sformatf("t3 repeat j%0d", j), obs[1][0], j == 13 || j == 16 || j == 19);
        end
        sync_v[1] = 1'b0;
        tick();
        check_bit("t3 release early", obs[1][2], 1'b0);
        tick();
        check_bit("t3 release", obs[1][2], 1'b1);
        check_bit("t3 repeat suppressed", obs[1][0], 1'b0);
        ticks(3);

        // u1: release accepted on the edge where the hold count would reach LONG_CYCLES.
        sync_v[1] = 1'b1;
        ticks(2);
        check_bit("t4 press", obs[1][3], 1'b1);
        ticks(8);
        sync_v[1] = 1'b0;
        tick();
        check_bit("t4 long pre", obs[1][1], 1'b0);
        tick();
        check_bit("t4 release", obs[1][2], 1'b1);
        check_bit("t4 long suppressed", obs[1][1], 1'b0);
        ticks(3);

        // u2: inverted input with repeats disabled.
        sync_v[2] = 1'b0;
        press_n = 0; long_n = 0; rep_n = 0;
        for (int j = 1; j <= 30; j++) begin
            tick();
            if (j == 3) check_bit("t5 press on low", obs[2][3], 1'b1);
            if (obs[2][3]) press_n++;
            if (obs[2][1]) long_n++;
            if (obs[2][0]) rep_n++;
        end
        check_int("t5 press count", press_n, 1);
        check_int("t5 long count", long_n, 1);
        check_int("t5 repeat count", rep_n, 0);
        sync_v[2] = 1'b1;
        ticks(5);

        // u0: reset pulse in the middle of a press with the input still high.
        sync_v[0] = 1'b1;
        ticks(5);
        check_bit("t6 level before reset", obs[0][4], 1'b1);
        #3;
        rst = 1'b1;
        #1;
        model_clear();
        for (int i = 0; i < 3; i++) check_vec($sformatf("t6 async reset u%0d", i), obs[i], 5'b0);
        ticks(2);
        rst = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            tick();
            check_bit($sformatf("t6 release after reset j%0d", j), obs[0][2], 1'b0);
            check_bit($sformatf("t6 fresh press j%0d", j), obs[0][3], j == 4);
        end
        sync_v[0] = 1'b0;
        ticks(6);

        // Random bounce runs mixed with long holds on all instances.
        for (int i = 0; i < 3; i++) rem[i] = 0;
        for (int n = 0; n < 900; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (rem[i] == 0) begin
                    sync_v[i] = ~sync_v[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 45))
                                                         : int'($urandom_range(1, 5));
                end else begin
                    rem[i]--;
                end
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fg_button_debouncer.md
# fg_button_debouncer

Debounces one already-synchronized push-button/control level and turns it into clean events for the function generator's control logic: debounced level, single-cycle press/release pulses, a long-press pulse and optional auto-repeat pulses while held. Sits directly downstream of the two-flop input synchronizer, one instance per front-panel button. It never sees raw asynchronous inputs.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive identical samples required to accept a level change; legal range 1 and above.
- LONG_CYCLES, 1024: cycles the debounced level must stay high after the press before long_o fires; legal range 1 and above.
- REPEAT_CYCLES, 256: period of repeat_o after long_o; legal range 1 and above.
- REPEAT_EN, 1: 1 enables repeat_o; 0 ties it low.
- INVERT, 0: 1 treats sync_i low as "pressed".
- clk_i  input  1  system clock; only clock in the block.
- rst_i  input  1  reset, asynchronous and active-high; clears all state.
- sync_i  input  1  synchronized button level, already in the clk_i domain.
- level_o  output  1  debounced pressed level, registered.
- press_o  output  1  one-cycle pulse on accepted press.
- release_o  output  1  one-cycle pulse on accepted release.
- long_o  output  1  one-cycle pulse when a press has lasted LONG_CYCLES.
- repeat_o  output  1  one-cycle pulse every REPEAT_CYCLES after long_o while still held.

## Operation
- Internal pressed sample p = sync_i XOR INVERT.
- FSM has four states:
  - STABLE_LO: level_o=0. If p=1, go to PEND_HI with deb_cnt=1.
  - PEND_HI: if p=0, go back to STABLE_LO and clear deb_cnt. If p=1, deb_cnt increments. When it reaches DEBOUNCE_CYCLES: go to STABLE_HI, set level_o=1, pulse press_o, clear hold_cnt.
  - STABLE_HI: level_o=1. If p=0, go to PEND_LO with deb_cnt=1.
  - PEND_LO: mirror of PEND_HI. On reaching the count: go to STABLE_LO, set level_o=0, pulse release_o.
- With DEBOUNCE_CYCLES=1, the PEND states are bypassed: the level changes on the first differing sample.
- hold_cnt increments every cycle while level_o=1, in both STABLE_HI and PEND_LO. It saturates at LONG_CYCLES.
- long_o pulses on the cycle hold_cnt reaches LONG_CYCLES, exactly once per press.
- After long_o, rep_cnt counts cycles. repeat_o pulses each time rep_cnt reaches REPEAT_CYCLES, then rep_cnt reloads to 0. This continues until release is accepted.
- A glitch back to the held level during PEND_LO does not disturb hold_cnt or rep_cnt.
- Simultaneous events: release acceptance wins. On the edge where release is accepted, long_o and repeat_o are suppressed, and hold_cnt and rep_cnt clear.
- press_o and release_o are never high in the same cycle. long_o and repeat_o are never high in the same cycle.
- Counter widths are $clog2(param+1) bits. Counters never wrap.

## Timing
- Reset values, immediate and asynchronous: state STABLE_LO, every counter 0, and level_o, press_o, release_o, long_o, repeat_o all 0. This holds even when sync_i is high during reset.
- Reset mid-press: all outputs drop to 0 at once. No release_o is generated.
- Press latency: if p=1 at rising edges k..k+D-1 (D=DEBOUNCE_CYCLES), then level_o and press_o go high after edge k+D-1. press_o drops after edge k+D.
- Release latency is symmetric.
- long_o is high for the one cycle after edge k+D-1+LONG_CYCLES.
- repeat_o pulse n (n≥1) is high for the one cycle after edge k+D-1+LONG_CYCLES+n·REPEAT_CYCLES.
- All outputs are registered. No combinational path from sync_i to any output.

## Test plan
- D=4, sync_i low-to-high and held 10 cycles from edge 5 -> level_o and press_o rise after edge 8; press_o lasts exactly 1 cycle; no other pulses.
- D=4, 3-cycle high glitch, then a 3-cycle low glitch while held -> no press_o on the first glitch; level_o stays 1 with no release_o on the second.
- D=2, L=10, R=3, hold 20 cycles after acceptance -> long_o at hold cycle 10; repeat_o at cycles 13, 16, 19; then release_o 2 cycles after sync_i falls.
- D=2, L=10, release accepted on the same edge as hold_cnt would reach 10 -> release_o=1, long_o=0.
- INVERT=1, REPEAT_EN=0, long hold -> press_o on low input; long_o fires; repeat_o stays 0.
- rst_i pulsed while in STABLE_HI with sync_i still high -> outputs 0 immediately; after reset release, a fresh press_o follows D cycles later.
